// File: rtl/muldiv_pkg.sv
// Shared encodings and FSM state type for the RV32M multiply/divide unit.
package muldiv_pkg;

   localparam logic [6:0] OPC_OP    = 7'b0110011;
   localparam logic [6:0] F7_MULDIV = 7'b0000001;

   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } md_state_e;

endpackage

// File: rtl/muldiv_iter_core.sv
// Shared 64-bit accumulator for shift-add multiply and restoring divide on
// unsigned magnitudes; one bit per step, 5-bit counter running 31 down to 0.
module muldiv_iter_core
   import muldiv_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load_i,
   input  logic        step_i,
   input  logic        div_i,
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   output logic [63:0] acc_nxt_o,
   output logic        last_o
);

   logic [63:0] acc_q, acc_d;
   logic [31:0] b_q, b_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        div_q, div_d;
   logic [32:0] sum;
   logic [32:0] diff;

   always_comb begin
      acc_d = acc_q;
      b_d   = b_q;
      cnt_d = cnt_q;
      div_d = div_q;
      sum   = {1'b0, acc_q[63:32]} + {1'b0, b_q};
      diff  = acc_q[63:31] - {1'b0, b_q};
      if (load_i) begin
         acc_d = {32'd0, a_i};
         b_d   = b_i;
         cnt_d = 5'd31;
         div_d = div_i;
      end else if (step_i) begin
         if (div_q) begin
            // Upper half holds the partial remainder, lower half shifts in quotient bits.
            if (!diff[32]) acc_d = {diff[31:0], acc_q[30:0], 1'b1};
            else           acc_d = {acc_q[62:0], 1'b0};
         end else begin
            if (acc_q[0]) acc_d = {sum, acc_q[31:1]};
            else          acc_d = {1'b0, acc_q[63:32], acc_q[31:1]};
         end
         if (cnt_q != 5'd0) cnt_d = cnt_q - 5'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
         b_q   <= '0;
         cnt_q <= '0;
         div_q <= 1'b0;
      end else begin
         acc_q <= acc_d;
         b_q   <= b_d;
         cnt_q <= cnt_d;
         div_q <= div_d;
      end
   end

   assign acc_nxt_o = acc_d;
   assign last_o    = (cnt_q == 5'd0);

endmodule

// File: rtl/ex_muldiv_unit.sv
// Execute-stage RV32M multiply/divide unit: FSM, sign handling, fast paths, result register.
// Optional MULDIV_FAST_MUL_EN: single-cycle multiply instead of the 32-step iteration.
module ex_muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [XLEN-1:0] ex_op1,
   input  logic [XLEN-1:0] ex_op2,
   input  logic [6:0]      ex_opcode,
   input  logic [6:0]      ex_func7,
   input  logic [2:0]      ex_func3,
   input  logic            ex_flush,
   input  logic            pipe_hold,
   output logic            md_stall,
   output logic            md_valid,
   output logic [XLEN-1:0] md_result
);

   md_state_e   state_q, state_d;
   logic        is_md, is_div, sgn_a, sgn_b, neg_a, neg_b;
   logic        div_zero, div_ovf, fast_mul, fast_path, capture;
   logic [31:0] abs_a, abs_b, div_fast_res, fast_res;
   logic [2:0]  f3_q;
   logic        res_neg_q, rem_neg_q, valid_q;
   logic [31:0] result_q, result_d;
   logic        core_load, core_step, core_last;
   logic [63:0] core_acc, prod;
   logic [31:0] quo, rem, iter_res;

   assign is_md  = (ex_opcode == OPC_OP) && (ex_func7 == F7_MULDIV);
   assign is_div = ex_func3[2];
   assign sgn_a  = is_div ? ~ex_func3[0] : ((ex_func3 == F3_MULH) || (ex_func3 == F3_MULHSU));
   assign sgn_b  = is_div ? ~ex_func3[0] : (ex_func3 == F3_MULH);
   assign neg_a  = sgn_a & ex_op1[31];
   assign neg_b  = sgn_b & ex_op2[31];
   assign abs_a  = neg_a ? (32'd0 - ex_op1) : ex_op1;
   assign abs_b  = neg_b ? (32'd0 - ex_op2) : ex_op2;

   assign div_zero = is_div && (ex_op2 == 32'd0);
   assign div_ovf  = ((ex_func3 == F3_DIV) || (ex_func3 == F3_REM)) &&
                     (ex_op1 == 32'h8000_0000) && (ex_op2 == 32'hFFFF_FFFF);
   assign div_fast_res = div_zero ? (ex_func3[1] ? ex_op1 : 32'hFFFF_FFFF)
                                  : (ex_func3[1] ? 32'd0  : 32'h8000_0000);

`ifdef MULDIV_FAST_MUL_EN
   logic signed [63:0] fa, fb, fprod;
   assign fa       = {{32{neg_a}}, ex_op1};
   assign fb       = {{32{neg_b}}, ex_op2};
   assign fprod    = fa * fb;
   assign fast_mul = ~is_div;
   assign fast_res = is_div ? div_fast_res
                            : ((ex_func3 == F3_MUL) ? fprod[31:0] : fprod[63:32]);
`else
   assign fast_mul = 1'b0;
   assign fast_res = div_fast_res;
`endif

   assign fast_path = div_zero | div_ovf | fast_mul;

   // Final sign fix-up uses the core's next accumulator so the result lands on entry to DONE.
   assign prod     = res_neg_q ? (64'd0 - core_acc) : core_acc;
   assign quo      = res_neg_q ? (32'd0 - core_acc[31:0]) : core_acc[31:0];
   assign rem      = rem_neg_q ? (32'd0 - core_acc[63:32]) : core_acc[63:32];
   assign iter_res = f3_q[2] ? (f3_q[1] ? rem : quo)
                             : ((f3_q == F3_MUL) ? prod[31:0] : prod[63:32]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (is_md && !ex_flush) state_d = fast_path ? DONE : CALC;
         CALC: begin
            if (ex_flush)       state_d = IDLE;
            else if (core_last) state_d = DONE;
         end
         DONE: if (ex_flush || !pipe_hold) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      capture   = (state_q == IDLE) && is_md && !ex_flush;
      core_load = capture && !fast_path;
      core_step = (state_q == CALC);
      md_stall  = rst_n && is_md && !ex_flush && ((state_q == IDLE) || (state_q == CALC));
      result_d  = result_q;
      if (capture && fast_path)
         result_d = fast_res;
      else if ((state_q == CALC) && core_last && !ex_flush)
         result_d = iter_res;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         f3_q      <= '0;
         res_neg_q <= 1'b0;
         rem_neg_q <= 1'b0;
         result_q  <= '0;
         valid_q   <= 1'b0;
      end else begin
         if (capture) begin
            f3_q      <= ex_func3;
            res_neg_q <= neg_a ^ neg_b;
            rem_neg_q <= neg_a;
         end
         result_q <= result_d;
         valid_q  <= (state_d == DONE);
      end
   end

   muldiv_iter_core u_core (
      .clk       (clk),
      .rst_n     (rst_n),
      .load_i    (core_load),
      .step_i    (core_step),
      .div_i     (is_div),
      .a_i       (abs_a),
      .b_i       (abs_b),
      .acc_nxt_o (core_acc),
      .last_o    (core_last)
   );

   assign md_valid  = valid_q;
   assign md_result = result_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed corner cases plus random ops
// against a plain-arithmetic RV32M reference model.
module tb_ex_muldiv_unit;
   import muldiv_pkg::*;

   logic        clk;
   logic        rst_n;
   logic [31:0] ex_op1, ex_op2;
   logic [6:0]  ex_opcode, ex_func7;
   logic [2:0]  ex_func3;
   logic        ex_flush, pipe_hold;
   logic        md_stall, md_valid;
   logic [31:0] md_result;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] last_res;

   ex_muldiv_unit #(.XLEN(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ex_op1    (ex_op1),
      .ex_op2    (ex_op2),
      .ex_opcode (ex_opcode),
      .ex_func7  (ex_func7),
      .ex_func3  (ex_func3),
      .ex_flush  (ex_flush),
      .pipe_hold (pipe_hold),
      .md_stall  (md_stall),
      .md_valid  (md_valid),
      .md_result (md_result)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #400000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ref_md(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      longint      sa, sb, p;
      logic [63:0] up;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (f3)
         F3_MUL:    begin p = sa * sb; return p[31:0]; end
         F3_MULH:   begin p = sa * sb; return p[63:32]; end
         F3_MULHSU: begin p = sa * longint'({32'd0, b}); return p[63:32]; end
         F3_MULHU:  begin up = {32'd0, a} * {32'd0, b}; return up[63:32]; end
         F3_DIV: begin
            if (b == 32'd0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            return 32'(sa / sb);
         end
         F3_DIVU: begin
            if (b == 32'd0) return 32'hFFFF_FFFF;
            return a / b;
         end
         F3_REM: begin
            if (b == 32'd0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
            return 32'(sa % sb);
         end
         default: begin
            if (b == 32'd0) return a;
            return a % b;
         end
      endcase
   endfunction

   function automatic bit is_fast(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      bit is_dv;
      is_dv = f3 inside {F3_DIV, F3_DIVU, F3_REM, F3_REMU};
      if (!is_dv) begin
`ifdef MULDIV_FAST_MUL_EN
         return 1'b1;
`else
         return 1'b0;
`endif
      end
      if (b == 32'd0) return 1'b1;
      if ((f3 == F3_DIV || f3 == F3_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [31:0] pick_val();
      case ($urandom_range(0, 7))
         0:       return 32'd0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'($urandom_range(1, 20));
         default: return $urandom;
      endcase
   endfunction

   task automatic set_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      ex_opcode = OPC_OP;
      ex_func7  = F7_MULDIV;
      ex_func3  = f3;
      ex_op1    = a;
      ex_op2    = b;
   endtask

   task automatic set_nop();
      ex_opcode = 7'b0010011;
      ex_func7  = 7'd0;
      ex_func3  = 3'd0;
      ex_op1    = $urandom;
      ex_op2    = $urandom;
   endtask

   // Issue one M op, scramble operands while it is busy, then retire it after `hold` held cycles.
   task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input int hold, input string tag);
      int          cyc, stalls, exp_stall;
      bit          got;
      logic [31:0] exp;
      exp       = ref_md(f3, a, b);
      exp_stall = is_fast(f3, a, b) ? 1 : 33;
      cyc = 0;
      stalls = 0;
      got = 1'b0;
      @(negedge clk);
      set_op(f3, a, b);
      for (int i = 0; i < 60 && !got; i++) begin
         #1;
         cyc++;
         if (md_valid) got = 1'b1;
         else begin
            if (md_stall) stalls++;
            @(negedge clk);
            ex_op1 = $urandom;
            ex_op2 = $urandom;
         end
      end
      if (!got) chk_eq({tag, "_timeout"}, {31'd0, md_valid}, 32'd1);
      else begin
         chk_eq({tag, "_res"}, md_result, exp);
         chk_eq({tag, "_cyc"}, 32'(cyc), 32'(exp_stall + 1));
         chk_eq({tag, "_stall"}, 32'(stalls), 32'(exp_stall));
      end
      pipe_hold = (hold > 0);
      for (int h = 1; h <= hold; h++) begin
         @(negedge clk);
         #1;
         chk_eq({tag, "_hold"}, {31'd0, md_valid}, 32'd1);
         if (h == hold) pipe_hold = 1'b0;
      end
      @(negedge clk);
      set_nop();
      #1;
      chk_eq({tag, "_retire"}, {31'd0, md_valid}, 32'd0);
      last_res = exp;
   endtask

   initial begin
      int vcount;
      rst_n     = 1'b0;
      ex_flush  = 1'b0;
      pipe_hold = 1'b0;
      set_op(F3_DIV, 32'd100, 32'd7);
      @(negedge clk);
      #1;
      chk_eq("rst_valid", {31'd0, md_valid}, 32'd0);
      chk_eq("rst_result", md_result, 32'd0);
      chk_eq("rst_stall", {31'd0, md_stall}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      set_nop();
      #1;
      chk_eq("idle_nop_stall", {31'd0, md_stall}, 32'd0);

      run_op(F3_MUL,    32'd7,         32'hFFFF_FFFD, 0, "mul_7x-3");
      run_op(F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mulhu_max");
      run_op(F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mulhsu_m1");
      run_op(F3_MULH,   32'h8000_0000, 32'h8000_0000, 0, "mulh_min");
      run_op(F3_DIV,    32'hFFFF_FFEC, 32'd3,         0, "div_-20_3");
      run_op(F3_REM,    32'hFFFF_FFEC, 32'd3,         0, "rem_-20_3");
      run_op(F3_DIVU,   32'd5,         32'd0,         0, "divu_by0");
      run_op(F3_REMU,   32'd5,         32'd0,         0, "remu_by0");
      run_op(F3_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 0, "div_ovf");
      run_op(F3_REM,    32'h8000_0000, 32'hFFFF_FFFF, 0, "rem_ovf");

      // Flush during CALC cycle 10 of a DIV.
      @(negedge clk);
      set_op(F3_DIV, 32'd1000, 32'd7);
      repeat (10) @(negedge clk);
      ex_flush = 1'b1;
      #1;
      chk_eq("flush_stall_now", {31'd0, md_stall}, 32'd0);
      @(negedge clk);
      ex_flush = 1'b0;
      set_nop();
      #1;
      chk_eq("flush_stall_next", {31'd0, md_stall}, 32'd0);
      chk_eq("flush_valid_next", {31'd0, md_valid}, 32'd0);
      chk_eq("flush_result_kept", md_result, last_res);
      vcount = 0;
      repeat (40) begin
         @(negedge clk);
         #1;
         if (md_valid) vcount++;
      end
      chk_eq("flush_no_valid", 32'(vcount), 32'd0);

      run_op(F3_DIV, 32'hFFFF_FFEC, 32'd3, 3, "div_hold3");

      // Flush wins over pipe_hold in DONE.
      @(negedge clk);
      set_op(F3_DIVU, 32'd9, 32'd0);
      @(negedge clk);
      #1;
      chk_eq("done_flush_valid_pre", {31'd0, md_valid}, 32'd1);
      pipe_hold = 1'b1;
      ex_flush  = 1'b1;
      @(negedge clk);
      pipe_hold = 1'b0;
      ex_flush  = 1'b0;
      set_nop();
      #1;
      chk_eq("done_flush_valid", {31'd0, md_valid}, 32'd0);
      chk_eq("done_flush_result", md_result, 32'hFFFF_FFFF);

      // Reset asserted at CALC cycle 20.
      @(negedge clk);
      set_op(F3_DIVU, 32'd12345, 32'd11);
      repeat (20) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk_eq("midrst_result", md_result, 32'd0);
      chk_eq("midrst_valid", {31'd0, md_valid}, 32'd0);
      chk_eq("midrst_stall", {31'd0, md_stall}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      set_nop();
      last_res = 32'd0;

      run_op(F3_REMU, 32'd12345, 32'd11, 1, "post_rst");

      for (int n = 0; n < 40; n++) begin
         logic [2:0]  f3;
         logic [31:0] a, b;
         f3 = 3'($urandom_range(0, 7));
         a  = pick_val();
         b  = pick_val();
         run_op(f3, a, b, $urandom_range(0, 2), $sformatf("rnd%0d_f%0d", n, f3));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ex_muldiv_unit.md
# ex_muldiv_unit

Multi-cycle RV32M multiply/divide unit in the execute stage, directly downstream of the ID/EX pipeline register. It consumes the operands and decode fields held in that register. When the instruction is an M-extension op, it stalls the front of the pipeline until a registered 32-bit result is ready. Non-M instructions pass through untouched; the main ALU's result mux selects `md_result` when `md_valid` is high.

## Interface
Parameters:
- `XLEN`, 32, operand and result width; only 32 is supported.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `ex_op1`  in  32  rs1 value (dividend / multiplicand).
- `ex_op2`  in  32  rs2 value (divisor / multiplier).
- `ex_opcode`  in  7  instruction opcode.
- `ex_func7`  in  7  func7 field.
- `ex_func3`  in  3  selects MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM or REMU.
- `ex_flush`  in  1  kill the instruction in EX (branch redirect).
- `pipe_hold`  in  1  a later stage is stalled; EX must not advance.
- `md_stall`  out  1  combinational; freezes PC, IF/ID and ID/EX.
- `md_valid`  out  1  registered; `md_result` belongs to the EX instruction this cycle.
- `md_result`  out  32  registered result.

## Operation
- M-op detect: `is_md = (ex_opcode == 7'b0110011) && (ex_func7 == 7'b0000001)`.
- States:
  - IDLE: on `is_md && !ex_flush`, capture operands, func3, sign flags and absolute values; go to CALC, or to DONE on a fast path.
  - CALC: one iteration per cycle; 5-bit counter runs 31 down to 0; go to DONE after the iteration with count 0.
  - DONE: `md_valid=1`; stay while `pipe_hold`, else go to IDLE.
- Fast paths from IDLE straight to DONE:
  - divide by zero: quotient `0xFFFFFFFF`, remainder = dividend.
  - signed overflow (`0x80000000 / -1`): quotient `0x80000000`, remainder 0.
  - multiply when `MULDIV_FAST_MUL_EN` is defined.
- Multiply:
  - unsigned 32x32 shift-add into a 64-bit accumulator on magnitudes.
  - negate the 64-bit product if exactly one signed operand is negative.
  - MULH and MULHSU use signed rs1; MULH also uses signed rs2.
  - MUL returns `[31:0]`; the MULH variants return `[63:32]`.
- Divide:
  - restoring division, one quotient bit per cycle, on magnitudes.
  - quotient is negated when the operand signs differ (DIV only).
  - remainder takes the sign of the dividend (REM only).
- `md_stall = is_md && (state == IDLE || state == CALC) && !ex_flush`.
- `ex_flush` in any state forces IDLE next cycle. `md_result` is left unchanged and `md_valid` drops.

## Timing
- Reset values: state IDLE, counter 0, `md_valid=0`, `md_result=0`, all datapath registers 0. `md_stall` reads 0 while `rst_n` is low.
- Iterative op occupancy in EX is 34 cycles: 1 IDLE capture, 32 CALC, 1 DONE. `md_stall` is high for the first 33.
- Fast-path occupancy is 2 cycles; `md_stall` is high for 1.
- DONE to IDLE is unconditional when `!pipe_hold`. A back-to-back M op is seen in IDLE on the following cycle, so there is no double issue.
- Operand changes on `ex_op*` during CALC are ignored because operands were captured at IDLE.
- Reset asserted mid-CALC aborts immediately to reset values.
- `ex_flush` and DONE in the same cycle: flush wins and `md_valid` falls next cycle.

## Configuration
- `MULDIV_FAST_MUL_EN`:
  - Defined: multiplies use a single-cycle 33x33 signed product, registered at IDLE, then DONE (2-cycle occupancy). Divides are unchanged.
  - Undefined: multiplies use the 32-cycle iterative path.
  - Both builds give bit-identical results.

## Structure
- `muldiv_pkg` holds:
  - `OPC_OP` (7'b0110011) and `F7_MULDIV`.
  - the eight func3 encodings.
  - the state enum {IDLE, CALC, DONE}.
- One sub-module, `muldiv_iter_core`: the shared 64-bit accumulator/shift datapath with its counter, selected for multiply or divide. `ex_muldiv_unit` owns the FSM, sign handling, fast paths and output register.

## Test plan
- MUL 7 × −3 (`0xFFFFFFFD`) → `md_result=0xFFFFFFEB`. Stall is 33 cycles iterative, or 1 cycle with `MULDIV_FAST_MUL_EN`.
- MULHU `0xFFFFFFFF` × `0xFFFFFFFF` → `0xFFFFFFFE`; MULHSU −1 × `0xFFFFFFFF` → `0xFFFFFFFF`.
- DIV −20 / 3 → `0xFFFFFFFA`; REM → `0xFFFFFFFE`; `md_valid` high exactly once, in cycle 34.
- DIVU 5 / 0 → `0xFFFFFFFF`; REMU 5 / 0 → 5; DIV `0x80000000` / −1 → `0x80000000`, REM → 0. All 2-cycle occupancy.
- DIV with `ex_flush` at CALC cycle 10 → IDLE next cycle, `md_stall` and `md_valid` low. With `pipe_hold` held 3 cycles in DONE → `md_valid` stays high 4 cycles, then a new DIV starts cleanly.
- `rst_n` pulled low at CALC cycle 20 → `md_result=0`, `md_valid=0`, `md_stall=0` immediately.
